// File: rtl/sobel_edge_engine.sv
// 3x3 Sobel edge engine with frame-latched controls and per-frame edge statistics.
// Latency 3 cycles, one pixel per clock, no backpressure (never stalls).
module sobel_edge_engine #(
    parameter int  PIX_W   = 8,
    parameter int  THR_RST = 100,
    parameter int  CNT_W   = 22,
    localparam int MAG_W   = PIX_W + 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [PIX_W-1:0] pixel_in1,
    input  logic [PIX_W-1:0] pixel_in2,
    input  logic [PIX_W-1:0] pixel_in3,
    input  logic [PIX_W-1:0] pixel_in4,
    input  logic [PIX_W-1:0] pixel_in5,
    input  logic [PIX_W-1:0] pixel_in6,
    input  logic [PIX_W-1:0] pixel_in7,
    input  logic [PIX_W-1:0] pixel_in8,
    input  logic [PIX_W-1:0] pixel_in9,
    input  logic             hsync,
    input  logic             vsync,
    input  logic             de,
    input  logic [MAG_W-1:0] threshold,
    input  logic [1:0]       mode,
    input  logic             norm_sel,
    output logic             hsync_out,
    output logic             vsync_out,
    output logic             de_out,
    output logic             edge_out,
    output logic [PIX_W-1:0] pixel_out,
    output logic [CNT_W-1:0] edge_count,
    output logic             count_valid
);

    localparam logic [MAG_W:0] PIX_MAX = {{(MAG_W-PIX_W+1){1'b0}}, {PIX_W{1'b1}}};

    logic [MAG_W-1:0]        thr_s, thr_1, thr_2;
    logic [1:0]              mode_s, mode_1, mode_2;
    logic                    norm_s, norm_1, norm_2;
    logic signed [MAG_W-1:0] gv_1, gh_1;
    logic [MAG_W-1:0]        av_2, ah_2;
    logic [PIX_W-1:0]        p5_1, p5_2;
    logic                    hs_1, hs_2, vs_1, vs_2, de_1, de_2;
    logic [CNT_W-1:0]        cnt, cnt_inc;
    logic [MAG_W-1:0]        sum_top, sum_bot, sum_lft, sum_rgt;
    logic [MAG_W:0]          mag;
    logic                    edge_c, frame_start, vs_rise;
    logic [PIX_W-1:0]        pix_c;

    // Sums are unsigned; the difference wraps into the signed result, which always fits.
    always_comb begin
        sum_top = MAG_W'(pixel_in1) + (MAG_W'(pixel_in2) << 1) + MAG_W'(pixel_in3);
        sum_bot = MAG_W'(pixel_in7) + (MAG_W'(pixel_in8) << 1) + MAG_W'(pixel_in9);
        sum_lft = MAG_W'(pixel_in1) + (MAG_W'(pixel_in4) << 1) + MAG_W'(pixel_in7);
        sum_rgt = MAG_W'(pixel_in3) + (MAG_W'(pixel_in6) << 1) + MAG_W'(pixel_in9);
    end

    assign frame_start = vsync & ~vs_1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            thr_s  <= MAG_W'(THR_RST);
            mode_s <= 2'd0;
            norm_s <= 1'b0;
        end else if (frame_start) begin
            thr_s  <= threshold;
            mode_s <= mode;
            norm_s <= norm_sel;
        end
    end

    // Shadow values travel with the window, so a frame-boundary update never splits a pixel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gv_1 <= '0; gh_1 <= '0; p5_1 <= '0;
            thr_1 <= '0; mode_1 <= '0; norm_1 <= 1'b0;
            hs_1 <= 1'b0; vs_1 <= 1'b0; de_1 <= 1'b0;
            av_2 <= '0; ah_2 <= '0; p5_2 <= '0;
            thr_2 <= '0; mode_2 <= '0; norm_2 <= 1'b0;
            hs_2 <= 1'b0; vs_2 <= 1'b0; de_2 <= 1'b0;
        end else begin
            gv_1   <= $signed(sum_top - sum_bot);
            gh_1   <= $signed(sum_lft - sum_rgt);
            p5_1   <= pixel_in5;
            thr_1  <= thr_s;
            mode_1 <= mode_s;
            norm_1 <= norm_s;
            hs_1   <= hsync;
            vs_1   <= vsync;
            de_1   <= de;
            av_2   <= gv_1[MAG_W-1] ? $unsigned(-gv_1) : $unsigned(gv_1);
            ah_2   <= gh_1[MAG_W-1] ? $unsigned(-gh_1) : $unsigned(gh_1);
            p5_2   <= p5_1;
            thr_2  <= thr_1;
            mode_2 <= mode_1;
            norm_2 <= norm_1;
            hs_2   <= hs_1;
            vs_2   <= vs_1;
            de_2   <= de_1;
        end
    end

    always_comb begin
        if (norm_2) mag = (av_2 > ah_2) ? {1'b0, av_2} : {1'b0, ah_2};
        else        mag = {1'b0, av_2} + {1'b0, ah_2};
        edge_c = de_2 && (mag > {1'b0, thr_2});
        pix_c  = '0;
        if (de_2) begin
            case (mode_2)
                2'd0:    pix_c = edge_c ? '1 : '0;
                2'd1:    pix_c = (mag > PIX_MAX) ? '1 : mag[PIX_W-1:0];
                2'd2:    pix_c = p5_2;
                default: pix_c = edge_c ? '0 : '1;
            endcase
        end
    end

    // The vsync_out rise is seen one stage early so count_valid lines up with it.
    assign vs_rise = vs_2 & ~vsync_out;
    assign cnt_inc = (de_out && edge_out && cnt != '1) ? cnt + 1'b1 : cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hsync_out   <= 1'b0;
            vsync_out   <= 1'b0;
            de_out      <= 1'b0;
            edge_out    <= 1'b0;
            pixel_out   <= '0;
            edge_count  <= '0;
            count_valid <= 1'b0;
            cnt         <= '0;
        end else begin
            hsync_out   <= hs_2;
            vsync_out   <= vs_2;
            de_out      <= de_2;
            edge_out    <= edge_c;
            pixel_out   <= pix_c;
            count_valid <= vs_rise;
            if (vs_rise) begin
                edge_count <= cnt_inc;
                cnt        <= '0;
            end else begin
                cnt        <= cnt_inc;
            end
        end
    end

endmodule

// File: tb/tb_sobel_edge_engine.sv
// Randomised scoreboard bench for sobel_edge_engine against an arithmetic reference model.
module tb_sobel_edge_engine;

    localparam int PIX_W   = 8;
    localparam int MAG_W   = 11;
    localparam int CNT_W   = 22;
    localparam int THR_RST = 100;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    typedef logic [8:0][7:0] win_t;
    typedef struct {
        int         due;
        logic       hs;
        logic       vs;
        logic       de;
        logic       edg;
        logic [7:0] pix;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    win_t             win = '0;
    logic             hsync = 1'b0, vsync = 1'b0, de = 1'b0;
    logic [MAG_W-1:0] threshold = '0;
    logic [1:0]       mode = '0;
    logic             norm_sel = 1'b0;
    logic             hsync_out, vsync_out, de_out, edge_out, count_valid;
    logic [PIX_W-1:0] pixel_out;
    logic [CNT_W-1:0] edge_count;

    sobel_edge_engine #(.PIX_W(PIX_W), .THR_RST(THR_RST), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .pixel_in1(win[0]), .pixel_in2(win[1]), .pixel_in3(win[2]),
        .pixel_in4(win[3]), .pixel_in5(win[4]), .pixel_in6(win[5]),
        .pixel_in7(win[6]), .pixel_in8(win[7]), .pixel_in9(win[8]),
        .hsync(hsync), .vsync(vsync), .de(de),
        .threshold(threshold), .mode(mode), .norm_sel(norm_sel),
        .hsync_out(hsync_out), .vsync_out(vsync_out), .de_out(de_out),
        .edge_out(edge_out), .pixel_out(pixel_out),
        .edge_count(edge_count), .count_valid(count_valid)
    );

    always #5 clk = ~clk;

    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    exp_t q[$];
    int   checks = 0, failures = 0;
    int   s_thr = THR_RST, s_mode = 0, s_norm = 0;
    bit   prev_vs = 1'b0;
    int   nxt_thr = THR_RST, nxt_mode = 0, nxt_norm = 0;
    int   m_cnt = 0, m_last = 0, dut_report = -1;
    bit   m_pv = 1'b0;
    exp_t me;
    bit   exp_cv;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%0d expected=%0d", name, cyc, act, exp);
        end
    endtask

    function automatic exp_t model(input win_t w, input logic h, input logic v, input logic d,
                                   input int thr, input int md, input int nrm);
        exp_t e;
        int gv, gh, av, ah, mag;
        gv  = (int'(w[0]) + 2 * int'(w[1]) + int'(w[2])) - (int'(w[6]) + 2 * int'(w[7]) + int'(w[8]));
        gh  = (int'(w[0]) + 2 * int'(w[3]) + int'(w[6])) - (int'(w[2]) + 2 * int'(w[5]) + int'(w[8]));
        av  = (gv < 0) ? -gv : gv;
        ah  = (gh < 0) ? -gh : gh;
        mag = (nrm != 0) ? ((av > ah) ? av : ah) : av + ah;
        e.due = 0;
        e.hs  = h;
        e.vs  = v;
        e.de  = d;
        e.edg = d && (mag > thr);
        if (!d)            e.pix = 8'd0;
        else if (md == 0)  e.pix = e.edg ? 8'd255 : 8'd0;
        else if (md == 1)  e.pix = (mag > 255) ? 8'd255 : 8'(mag);
        else if (md == 2)  e.pix = w[4];
        else               e.pix = e.edg ? 8'd0 : 8'd255;
        return e;
    endfunction

    function automatic win_t flat(input int v);
        win_t w;
        for (int i = 0; i < 9; i++) w[i] = 8'(v);
        return w;
    endfunction

    function automatic win_t top_row(input int v);
        win_t w = '0;
        for (int i = 0; i < 3; i++) w[i] = 8'(v);
        return w;
    endfunction

    function automatic win_t gv100();
        win_t w = '0;
        w[1] = 8'd50;
        return w;
    endfunction

    function automatic win_t rand_win();
        win_t w;
        int k = $urandom_range(0, 3);
        int a = $urandom_range(0, 255);
        int b = $urandom_range(0, 255);
        for (int i = 0; i < 9; i++) begin
            case (k)
                0:       w[i] = 8'($urandom);
                1:       w[i] = (i < 3) ? 8'(a) : ((i >= 6) ? 8'(b) : 8'($urandom));
                2:       w[i] = (i % 3 == 0) ? 8'(a) : ((i % 3 == 2) ? 8'(b) : 8'((a + b) / 2));
                default: w[i] = 8'(a);
            endcase
        end
        return w;
    endfunction

    task automatic step(input win_t w, input logic h, input logic v, input logic d);
        exp_t e;
        @(negedge clk);
        win = w; hsync = h; vsync = v; de = d;
        threshold = MAG_W'(nxt_thr); mode = 2'(nxt_mode); norm_sel = 1'(nxt_norm);
        e = model(w, h, v, d, s_thr, s_mode, s_norm);
        e.due = cyc + 3;
        q.push_back(e);
        if (v && !prev_vs) begin
            s_thr = nxt_thr; s_mode = nxt_mode; s_norm = nxt_norm;
        end
        prev_vs = v;
    endtask

    task automatic pulse(input int thr, input int md, input int nrm);
        nxt_thr = thr; nxt_mode = md; nxt_norm = nrm;
        step('0, 1'b0, 1'b1, 1'b0);
        step('0, 1'b0, 1'b1, 1'b0);
        step('0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_hsync_out"}, int'(hsync_out), 0);
        chk({tag, "_vsync_out"}, int'(vsync_out), 0);
        chk({tag, "_de_out"}, int'(de_out), 0);
        chk({tag, "_edge_out"}, int'(edge_out), 0);
        chk({tag, "_pixel_out"}, int'(pixel_out), 0);
        chk({tag, "_edge_count"}, int'(edge_count), 0);
        chk({tag, "_count_valid"}, int'(count_valid), 0);
    endtask

    task automatic mid_reset();
        @(negedge clk);
        hsync = 1'b0; vsync = 1'b0; de = 1'b0;
        #2 rst_n = 1'b0;
        #1 chk_outputs_zero("async_reset");
        @(negedge clk);
        #2 rst_n = 1'b1;
        s_thr = THR_RST; s_mode = 0; s_norm = 0; prev_vs = 1'b0;
    endtask

    // Scoreboard monitor: pops the entry due this cycle and tracks frame statistics.
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            m_cnt = 0; m_last = 0; m_pv = 1'b0;
        end else if (q.size() > 0 && q[0].due == cyc) begin
            me = q.pop_front();
            chk("hsync_out", int'(hsync_out), int'(me.hs));
            chk("vsync_out", int'(vsync_out), int'(me.vs));
            chk("de_out", int'(de_out), int'(me.de));
            chk("edge_out", int'(edge_out), int'(me.edg));
            chk("pixel_out", int'(pixel_out), int'(me.pix));
            exp_cv = me.vs && !m_pv;
            if (exp_cv) begin
                m_last = m_cnt;
                m_cnt  = (me.de && me.edg) ? 1 : 0;
            end else if (me.de && me.edg && m_cnt < CNT_MAX) begin
                m_cnt++;
            end
            m_pv = me.vs;
            chk("count_valid", int'(count_valid), int'(exp_cv));
            chk("edge_count", int'(edge_count), m_last);
        end
        if (rst_n && count_valid) dut_report = int'(edge_count);
    end

    initial begin
        int n;
        repeat (3) @(negedge clk);
        #1 chk_outputs_zero("reset");
        #1 rst_n = 1'b1;
        repeat (4) step('0, 1'b0, 1'b0, 1'b0);

        repeat (3) step(flat(100), 1'b1, 1'b0, 1'b1);
        repeat (2) step(top_row(255), 1'b0, 1'b0, 1'b1);
        pulse(100, 2, 0);
        repeat (2) step(flat(100), 1'b1, 1'b0, 1'b1);
        pulse(100, 1, 0);
        step(top_row(255), 1'b0, 1'b0, 1'b1);
        step(gv100(), 1'b0, 1'b0, 1'b1);
        nxt_thr = 99;
        step(gv100(), 1'b0, 1'b0, 1'b1);
        pulse(99, 1, 0);
        step(gv100(), 1'b0, 1'b0, 1'b1);
        pulse(100, 0, 0);
        nxt_thr = 2000;
        step(top_row(255), 1'b0, 1'b0, 1'b1);
        pulse(2000, 0, 0);
        step(top_row(255), 1'b0, 1'b0, 1'b1);
        pulse(600, 3, 1);
        repeat (6) step(rand_win(), 1'b0, 1'b0, 1'b1);

        pulse(100, 0, 0);
        for (int i = 0; i < 10; i++) begin
            step(top_row(255), 1'b0, 1'b0, 1'b1);
            step(flat(100), 1'b0, 1'b0, 1'b1);
            step(top_row(255), 1'b0, 1'b0, 1'b0);
        end
        pulse(100, 0, 0);
        repeat (3) step('0, 1'b0, 1'b0, 1'b0);
        chk("frame10_edge_count", dut_report, 10);

        for (int f = 0; f < 40; f++) begin
            pulse($urandom_range(0, 1500), $urandom_range(0, 3), $urandom_range(0, 1));
            n = $urandom_range(20, 60);
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 9) == 0) begin
                    nxt_thr  = $urandom_range(0, 2047);
                    nxt_mode = $urandom_range(0, 3);
                    nxt_norm = $urandom_range(0, 1);
                end
                step(rand_win(), 1'($urandom), 1'b0, $urandom_range(0, 3) != 0);
                if (f == 20 && i == n / 2) begin
                    mid_reset();
                    step(flat(100), 1'b0, 1'b0, 1'b1);
                    step(gv100(), 1'b0, 1'b0, 1'b1);
                    step(top_row(255), 1'b0, 1'b0, 1'b1);
                end
            end
        end

        repeat (6) step('0, 1'b0, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        #1 chk("queue_drained", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
